// File: rtl/seven_seg_capture_pkg.sv
// seven_seg_capture_pkg: active-low segment patterns (CA..CG) for 0-F and minus, plus capture FSM states
package seven_seg_capture_pkg;
  localparam logic [6:0] SEG_0 = 7'b0000001;
  localparam logic [6:0] SEG_1 = 7'b1001111;
  localparam logic [6:0] SEG_2 = 7'b0010010;
  localparam logic [6:0] SEG_3 = 7'b0000110;
  localparam logic [6:0] SEG_4 = 7'b1001100;
  localparam logic [6:0] SEG_5 = 7'b0100100;
  localparam logic [6:0] SEG_6 = 7'b0100000;
  localparam logic [6:0] SEG_7 = 7'b0001111;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0000100;
  localparam logic [6:0] SEG_A = 7'b0001000;
  localparam logic [6:0] SEG_B = 7'b1100000;
  localparam logic [6:0] SEG_C = 7'b0110001;
  localparam logic [6:0] SEG_D = 7'b1000010;
  localparam logic [6:0] SEG_E = 7'b0110000;
  localparam logic [6:0] SEG_F = 7'b0111000;
  localparam logic [6:0] SEG_MINUS = 7'b1111110;
  localparam logic [6:0] SEG_TABLE [16] = '{SEG_0, SEG_1, SEG_2, SEG_3, SEG_4, SEG_5, SEG_6, SEG_7,
                                            SEG_8, SEG_9, SEG_A, SEG_B, SEG_C, SEG_D, SEG_E, SEG_F};
  typedef enum logic [1:0] {WAIT, SETTLE, HELD} state_t;
endpackage

// File: rtl/seven_seg_capture_if.sv
// seven_seg_capture_if: display bus (an/seg/dp, active-low) and reconstructed frame outputs
//   master: display driver side (drives an/seg/dp, observes results)
//   slave : capture side (observes an/seg/dp, drives value/masks/frame_valid/scan_lost)
interface seven_seg_capture_if #(parameter int N = 8);
  logic [N-1:0] an;
  logic [6:0] seg;
  logic dp;
  logic [4*N-1:0] value;
  logic [N-1:0] dp_mask;
  logic [N-1:0] neg_mask;
  logic [N-1:0] err_mask;
  logic frame_valid;
  logic scan_lost;
  modport master(output an, seg, dp, input value, dp_mask, neg_mask, err_mask, frame_valid, scan_lost);
  modport slave(input an, seg, dp, output value, dp_mask, neg_mask, err_mask, frame_valid, scan_lost);
endinterface

// File: rtl/seven_seg_capture_decode.sv
// seg_pattern_decode: active-low seg[6:0] -> nibble, minus flag, error flag (nibble 0 unless a hex digit)
//   i_seg    : cathode pattern, bit6=CA ... bit0=CG
//   o_nibble : decoded hex value
//   o_neg    : pattern is the minus sign
//   o_err    : pattern is neither a hex digit nor minus
module seg_pattern_decode
  import seven_seg_capture_pkg::*;
(
  input  logic [6:0] i_seg,
  output logic [3:0] o_nibble,
  output logic       o_neg,
  output logic       o_err
);
  always_comb begin
    o_nibble = '0;
    o_neg = (i_seg == SEG_MINUS);
    o_err = !o_neg;
    for (int i = 0; i < 16; i++)
      if (i_seg == SEG_TABLE[i]) begin
        o_nibble = 4'(i);
        o_err = 1'b0;
      end
  end
endmodule

// File: rtl/seven_seg_capture.sv
// seven_seg_capture: snoops a multiplexed active-low 7-segment bus and rebuilds the displayed frame
//   clk, reset : system clock, synchronous active-high reset
//   bus.slave  : an/seg/dp in (async to clk); value, dp/neg/err masks, frame_valid pulse, scan_lost out
module seven_seg_capture
  import seven_seg_capture_pkg::*;
#(
  parameter int NUM_DIGITS = 8,
  parameter int SETTLE_CYCLES = 16,
  parameter int TIMEOUT_CYCLES = 200000
) (
  input logic clk,
  input logic reset,
  seven_seg_capture_if.slave bus
);
  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int KW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
  localparam int SNW = NUM_DIGITS + 8;
  logic [NUM_DIGITS-1:0] r_an_m, r_an;
  logic [6:0] r_seg_m, r_seg;
  logic r_dp_m, r_dp;
  logic [SNW-1:0] r_snap, w_snap;
  logic [SW-1:0] r_cnt;
  logic [TW-1:0] r_idle;
  state_t r_state, w_next;
  logic [NUM_DIGITS-1:0] w_sel;
  logic w_onehot, w_same, w_cap, w_frame, w_hit;
  logic [KW-1:0] w_k;
  logic [3:0] w_nib;
  logic w_neg, w_err;
  logic [4*NUM_DIGITS-1:0] r_wval, w_val, r_value;
  logic [NUM_DIGITS-1:0] r_wdp, r_wneg, r_werr, r_seen, w_dpm, w_negm, w_errm, w_seen;
  logic [NUM_DIGITS-1:0] r_dp_mask, r_neg_mask, r_err_mask;
  logic r_fv;
  always_ff @(posedge clk) begin
    if (reset) begin
      {r_an_m, r_an} <= '1;
      {r_seg_m, r_seg} <= '1;
      {r_dp_m, r_dp} <= '1;
    end else begin
      {r_an_m, r_an} <= {bus.an, r_an_m};
      {r_seg_m, r_seg} <= {bus.seg, r_seg_m};
      {r_dp_m, r_dp} <= {bus.dp, r_dp_m};
    end
  end
  assign w_snap = {r_an, r_seg, r_dp};
  assign w_sel = ~r_an;
  assign w_onehot = (w_sel != '0) && ((w_sel & (w_sel - 1'b1)) == '0);
  assign w_same = (w_snap == r_snap);
  always_comb begin
    w_k = '0;
    for (int i = 0; i < NUM_DIGITS; i++)
      if (w_sel[i]) w_k = KW'(i);
  end
  seg_pattern_decode u_dec (.i_seg(r_seg), .o_nibble(w_nib), .o_neg(w_neg), .o_err(w_err));
  always_comb begin
    w_next = r_state;
    w_cap = 1'b0;
    case (r_state)
      WAIT: w_next = w_onehot ? SETTLE : WAIT;
      SETTLE: begin
        w_cap = w_onehot && w_same && r_cnt >= SW'(SETTLE_CYCLES - 1);
        w_next = !w_onehot ? WAIT : w_cap ? HELD : SETTLE;
      end
      HELD: w_next = (r_an != r_snap[SNW-1 -: NUM_DIGITS]) ? WAIT : HELD;
      default: w_next = WAIT;
    endcase
  end
  always_comb begin
    w_val = r_wval;
    w_dpm = r_wdp;
    w_negm = r_wneg;
    w_errm = r_werr;
    w_seen = r_seen;
    if (w_cap) begin
      w_val[4*w_k +: 4] = w_nib;
      w_dpm[w_k] = ~r_dp;
      w_negm[w_k] = w_neg;
      w_errm[w_k] = w_err;
      w_seen[w_k] = 1'b1;
    end
  end
  assign w_frame = w_cap && (&w_seen);
  // seen is dropped on the edge the idle counter saturates so a resumed scan starts a fresh frame
  assign w_hit = !w_cap && r_idle == TW'(TIMEOUT_CYCLES - 1);
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= WAIT;
      r_snap <= '0;
      r_cnt <= '0;
      r_idle <= '0;
      r_wval <= '0;
      r_wdp <= '0;
      r_wneg <= '0;
      r_werr <= '0;
      r_seen <= '0;
      r_value <= '0;
      r_dp_mask <= '0;
      r_neg_mask <= '0;
      r_err_mask <= '0;
      r_fv <= 1'b0;
    end else begin
      r_state <= w_next;
      // outside HELD a one-hot pattern (re)starts or extends the stability count
      if (r_state != HELD && w_onehot) begin
        r_snap <= w_snap;
        r_cnt <= (r_state == SETTLE && w_same) ? r_cnt + 1'b1 : SW'(1);
      end
      r_idle <= w_cap ? '0 : (r_idle == TW'(TIMEOUT_CYCLES)) ? r_idle : r_idle + 1'b1;
      r_wval <= w_val;
      r_wdp <= w_dpm;
      r_wneg <= w_negm;
      r_werr <= w_errm;
      r_seen <= (w_frame || w_hit) ? '0 : w_seen;
      r_fv <= w_frame;
      if (w_frame) begin
        r_value <= w_val;
        r_dp_mask <= w_dpm;
        r_neg_mask <= w_negm;
        r_err_mask <= w_errm;
      end
    end
  end
  assign bus.value = r_value;
  assign bus.dp_mask = r_dp_mask;
  assign bus.neg_mask = r_neg_mask;
  assign bus.err_mask = r_err_mask;
  assign bus.frame_valid = r_fv;
  assign bus.scan_lost = (r_idle == TW'(TIMEOUT_CYCLES));
endmodule

// File: tb/tb_seven_seg_capture.sv
// tb_seven_seg_capture: directed scans of a 4-digit display bus with hand-computed frames
module tb_seven_seg_capture;
  localparam int N = 4;
  localparam int S = 4;
  localparam int T = 100;
  localparam logic [6:0] P1 = 7'b1001111, P2 = 7'b0010010, P3 = 7'b0000110, P4 = 7'b1001100;
  localparam logic [6:0] P5 = 7'b0100100, P6 = 7'b0100000, P7 = 7'b0001111, P8 = 7'b0000000;
  localparam logic [6:0] P9 = 7'b0000100, PA = 7'b0001000, PB = 7'b1100000, PC = 7'b0110001;
  localparam logic [6:0] PD = 7'b1000010, PMIN = 7'b1111110, PBAD = 7'b1111111;
  logic clk, reset;
  int errors = 0, checks = 0, fv_cnt = 0, f0;
  seven_seg_capture_if #(.N(N)) bus ();
  seven_seg_capture #(.NUM_DIGITS(N), .SETTLE_CYCLES(S), .TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );
  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end
  always @(negedge clk) if (bus.frame_valid === 1'b1) fv_cnt++;
  task automatic show(input int k, input logic [6:0] s, input logic d, input int n);
    bus.an = ~(4'(1) << k);
    bus.seg = s;
    bus.dp = d;
    repeat (n) @(negedge clk);
  endtask
  task automatic blank(input int n);
    bus.an = '1;
    bus.seg = '1;
    bus.dp = 1'b1;
    repeat (n) @(negedge clk);
  endtask
  task automatic test_reset;
    reset = 1'b1;
    blank(3);
    checks++; if (bus.value !== 16'h0) begin errors++; $display("FAIL reset_value got %h want 0000", bus.value); end
    checks++; if (bus.dp_mask !== 4'b0) begin errors++; $display("FAIL reset_dp got %b want 0000", bus.dp_mask); end
    checks++; if (bus.neg_mask !== 4'b0) begin errors++; $display("FAIL reset_neg got %b want 0000", bus.neg_mask); end
    checks++; if (bus.err_mask !== 4'b0) begin errors++; $display("FAIL reset_err got %b want 0000", bus.err_mask); end
    checks++; if (bus.frame_valid !== 1'b0) begin errors++; $display("FAIL reset_fv got %b want 0", bus.frame_valid); end
    checks++; if (bus.scan_lost !== 1'b0) begin errors++; $display("FAIL reset_lost got %b want 0", bus.scan_lost); end
    reset = 1'b0;
    blank(2);
  endtask
  task automatic test_frame;
    f0 = fv_cnt;
    show(0, P1, 1, 10); show(1, P2, 1, 10); show(2, P3, 0, 10); show(3, PA, 1, 10);
    blank(3);
    checks++; if (fv_cnt - f0 !== 1) begin errors++; $display("FAIL frame_count got %0d want 1", fv_cnt - f0); end
    checks++; if (bus.value !== 16'hA321) begin errors++; $display("FAIL frame_value got %h want a321", bus.value); end
    checks++; if (bus.dp_mask !== 4'b0100) begin errors++; $display("FAIL frame_dp got %b want 0100", bus.dp_mask); end
    checks++; if (bus.neg_mask !== 4'b0) begin errors++; $display("FAIL frame_neg got %b want 0000", bus.neg_mask); end
    checks++; if (bus.err_mask !== 4'b0) begin errors++; $display("FAIL frame_err got %b want 0000", bus.err_mask); end
    checks++; if (bus.scan_lost !== 1'b0) begin errors++; $display("FAIL frame_lost got %b want 0", bus.scan_lost); end
  endtask
  task automatic test_neg_err;
    f0 = fv_cnt;
    show(0, P1, 1, 10); show(1, PBAD, 1, 10); show(2, P2, 1, 10); show(3, PMIN, 1, 10);
    blank(3);
    checks++; if (fv_cnt - f0 !== 1) begin errors++; $display("FAIL negerr_count got %0d want 1", fv_cnt - f0); end
    checks++; if (bus.value !== 16'h0201) begin errors++; $display("FAIL negerr_value got %h want 0201", bus.value); end
    checks++; if (bus.neg_mask !== 4'b1000) begin errors++; $display("FAIL negerr_neg got %b want 1000", bus.neg_mask); end
    checks++; if (bus.err_mask !== 4'b0010) begin errors++; $display("FAIL negerr_err got %b want 0010", bus.err_mask); end
    checks++; if (bus.dp_mask !== 4'b0000) begin errors++; $display("FAIL negerr_dp got %b want 0000", bus.dp_mask); end
  endtask
  task automatic test_glitch;
    int first;
    show(0, P5, 1, 10); show(1, P7, 1, 10); show(2, P8, 1, 10);
    f0 = fv_cnt;
    for (int i = 0; i < 10; i++) begin
      show(3, P2, 1, 2);
      show(3, P5, 1, 2);
    end
    checks++; if (fv_cnt !== f0) begin errors++; $display("FAIL glitch_nocap got %0d frames want 0", fv_cnt - f0); end
    bus.seg = P1;
    first = 0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (bus.frame_valid === 1'b1 && first == 0) first = i;
    end
    checks++; if (first !== S + 2) begin errors++; $display("FAIL glitch_latency got %0d want %0d", first, S + 2); end
    blank(3);
    checks++; if (fv_cnt - f0 !== 1) begin errors++; $display("FAIL glitch_count got %0d want 1", fv_cnt - f0); end
    checks++; if (bus.value !== 16'h1875) begin errors++; $display("FAIL glitch_value got %h want 1875", bus.value); end
  endtask
  task automatic test_blank_repeat;
    f0 = fv_cnt;
    show(0, P5, 1, 10); show(1, P2, 1, 10); show(2, P3, 1, 10);
    bus.an = 4'b0110;
    bus.seg = P8;
    repeat (20) @(negedge clk);
    checks++; if (fv_cnt !== f0) begin errors++; $display("FAIL twolow_nocap got %0d frames want 0", fv_cnt - f0); end
    show(0, P7, 1, 10);
    checks++; if (fv_cnt !== f0) begin errors++; $display("FAIL repeat_nocap got %0d frames want 0", fv_cnt - f0); end
    show(3, P4, 1, 10);
    blank(3);
    checks++; if (fv_cnt - f0 !== 1) begin errors++; $display("FAIL repeat_count got %0d want 1", fv_cnt - f0); end
    checks++; if (bus.value !== 16'h4327) begin errors++; $display("FAIL repeat_value got %h want 4327", bus.value); end
  endtask
  task automatic test_timeout;
    f0 = fv_cnt;
    show(1, P1, 1, 10); show(2, P1, 1, 10); show(3, P1, 1, 10);
    blank(T + 10);
    checks++; if (bus.scan_lost !== 1'b1) begin errors++; $display("FAIL timeout_lost got %b want 1", bus.scan_lost); end
    checks++; if (bus.value !== 16'h4327) begin errors++; $display("FAIL timeout_hold got %h want 4327", bus.value); end
    checks++; if (fv_cnt !== f0) begin errors++; $display("FAIL timeout_nofv got %0d frames want 0", fv_cnt - f0); end
    show(0, P9, 1, 10);
    checks++; if (bus.scan_lost !== 1'b0) begin errors++; $display("FAIL resume_lost got %b want 0", bus.scan_lost); end
    checks++; if (fv_cnt !== f0) begin errors++; $display("FAIL resume_stale got %0d frames want 0", fv_cnt - f0); end
    show(1, P8, 1, 10);
    show(0, PA, 1, 10); show(1, PB, 1, 10); show(2, PC, 1, 10); show(3, PD, 1, 10);
    blank(3);
    checks++; if (fv_cnt - f0 !== 1) begin errors++; $display("FAIL resume_count got %0d want 1", fv_cnt - f0); end
    checks++; if (bus.value !== 16'hDCBA) begin errors++; $display("FAIL resume_value got %h want dcba", bus.value); end
  endtask
  task automatic test_reset_mid;
    show(0, P1, 1, 10); show(1, P2, 0, 10);
    bus.an = '1;
    reset = 1'b1;
    @(negedge clk);
    checks++; if (bus.value !== 16'h0) begin errors++; $display("FAIL midreset_value got %h want 0000", bus.value); end
    checks++; if (bus.dp_mask !== 4'b0) begin errors++; $display("FAIL midreset_dp got %b want 0000", bus.dp_mask); end
    reset = 1'b0;
    blank(2);
    f0 = fv_cnt;
    show(2, P5, 1, 10); show(3, P6, 1, 10);
    checks++; if (fv_cnt !== f0) begin errors++; $display("FAIL midreset_stale got %0d frames want 0", fv_cnt - f0); end
    show(0, P3, 1, 10);
    checks++; if (fv_cnt !== f0) begin errors++; $display("FAIL midreset_early got %0d frames want 0", fv_cnt - f0); end
    show(1, P4, 1, 10);
    blank(3);
    checks++; if (fv_cnt - f0 !== 1) begin errors++; $display("FAIL midreset_count got %0d want 1", fv_cnt - f0); end
    checks++; if (bus.value !== 16'h6543) begin errors++; $display("FAIL midreset_value2 got %h want 6543", bus.value); end
  endtask
  initial begin
    reset = 1'b1;
    bus.an = '1;
    bus.seg = '1;
    bus.dp = 1'b1;
    @(negedge clk);
    test_reset;
    test_frame;
    test_neg_err;
    test_glitch;
    test_blank_repeat;
    test_timeout;
    test_reset_mid;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
